// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DAT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr_i, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic               any_valid_o
);

    int   idx;
    logic found;

    always_comb begin
        pick_o      = '0;
        any_valid_o = |valid_i;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // explicit wrap keeps non-power-of-two requester counts in range
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && valid_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding byte streams to a Wishbone UART transmitter,
// with packet locking so multi-byte packets are never interleaved.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DAT_WIDTH    = UART_DAT_WIDTH,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DAT_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic                         wb_we_o,
    output logic [DAT_WIDTH-1:0]         wb_dat_o,
    input  logic                         wb_ack_i,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic                 last_q, last_d;

    logic [NUM_REQ-1:0]   pick;
    logic                 any_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     owner_inc;
    logic [PTR_W-1:0]     acc_idx;
    logic                 accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid_i     (req_valid_i),
        .ptr_i       (ptr_q),
        .pick_o      (pick),
        .any_valid_o (any_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign owner_inc = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        dat_d       = dat_q;
        last_d      = last_q;
        req_ready_o = '0;
        accept      = 1'b0;
        acc_idx     = owner_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    accept  = 1'b1;
                    acc_idx = pick_idx;
                end
            end
            XFER: begin
                if (wb_ack_i) begin
                    if (last_q) begin
                        state_d = IDLE;
                        ptr_d   = owner_inc;
                    end else begin
                        state_d = LOCK;
                        cnt_d   = '0;
                    end
                end
            end
            LOCK: begin
                // owner beats an expiring timeout in the same cycle
                if (req_valid_i[owner_q]) begin
                    accept = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    ptr_d   = owner_inc;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // ready must stay low while reset is held, even in IDLE
        if (accept && rst_ni) begin
            req_ready_o[acc_idx] = 1'b1;
            dat_d                = req_data_i[acc_idx*DAT_WIDTH +: DAT_WIDTH];
            last_d               = req_last_i[acc_idx];
            owner_d              = acc_idx;
            state_d              = XFER;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            last_q  <= last_d;
        end
    end

    assign wb_cyc_o = (state_q == XFER);
    assign wb_stb_o = (state_q == XFER);
    assign wb_we_o  = (state_q == XFER);
    assign wb_dat_o = (state_q == XFER) ? dat_q : '0;
    assign busy_o   = (state_q != IDLE);
    assign grant_o  = (state_q == IDLE) ? '0 : (NUM_REQ'(1) << owner_q);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: a 4-requester instance for ordering, locking, timeout and reset,
// plus a 3-requester instance for non-power-of-two round-robin wrap.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  v4 = '0, l4 = '0, rdy4, g4;
    logic [31:0] d4 = '0;
    logic        ack4 = 1'b0, cyc4, stb4, we4, busy4;
    logic [7:0]  dat4;

    logic [2:0]  v3 = '0, l3 = '0, rdy3, g3;
    logic [23:0] d3 = 24'h332211;
    logic        ack3 = 1'b0, cyc3, stb3, we3, busy3;
    logic [7:0]  dat3;

    int n_pass = 0;
    int n_tot  = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .DAT_WIDTH(8), .LOCK_TIMEOUT(8)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v4), .req_data_i(d4), .req_last_i(l4),
        .req_ready_o(rdy4), .wb_cyc_o(cyc4), .wb_stb_o(stb4), .wb_we_o(we4),
        .wb_dat_o(dat4), .wb_ack_i(ack4), .grant_o(g4), .busy_o(busy4)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .DAT_WIDTH(8), .LOCK_TIMEOUT(8)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v3), .req_data_i(d3), .req_last_i(l3),
        .req_ready_o(rdy3), .wb_cyc_o(cyc3), .wb_stb_o(stb3), .wb_we_o(we3),
        .wb_dat_o(dat3), .wb_ack_i(ack3), .grant_o(g3), .busy_o(busy3)
    );

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        ack;
        logic [3:0]  rdy;
        logic        cyc;
        logic [7:0]  dat;
        logic [3:0]  g;
        logic        b;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                input logic ack, input logic [3:0] rdy, input logic cyc,
                                input logic [7:0] dat, input logic [3:0] g, input logic b);
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.ack = ack;
        r.rdy = rdy; r.cyc = cyc; r.dat = dat; r.g = g; r.b = b;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    task automatic check4(input string nm, input logic [3:0] rdy, input logic cyc,
                          input logic [7:0] dat, input logic [3:0] g, input logic b);
        chk({nm, ".ready"}, 32'(rdy4), 32'(rdy));
        chk({nm, ".cyc"},   32'(cyc4), 32'(cyc));
        chk({nm, ".stbwe"}, 32'({stb4, we4}), 32'({cyc, cyc}));
        chk({nm, ".dat"},   32'(dat4), 32'(dat));
        chk({nm, ".grant"}, 32'(g4),   32'(g));
        chk({nm, ".busy"},  32'(busy4), 32'(b));
    endtask

    task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                          input logic ack);
        v4 = v; l4 = l; d4 = d; ack4 = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DA  = 32'hD3C241A0;
    localparam logic [31:0] D42 = 32'hD3C242A0;
    localparam logic [31:0] D43 = 32'hD3C243A0;
    localparam logic [31:0] D55 = 32'hD3C255A0;
    localparam logic [31:0] D66 = 32'hD3C25566;
    localparam logic [31:0] D77 = 32'hD3C25577;

    initial begin
        int         k;
        logic [2:0] e3;

        vt[0]  = mk(4'b0101, 4'b0101, DA,  1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0);
        vt[1]  = mk(4'b0100, 4'b0101, DA,  1'b0, 4'b0000, 1'b1, 8'hA0, 4'b0001, 1'b1);
        vt[2]  = mk(4'b0100, 4'b0101, DA,  1'b1, 4'b0000, 1'b1, 8'hA0, 4'b0001, 1'b1);
        vt[3]  = mk(4'b0100, 4'b0101, DA,  1'b0, 4'b0100, 1'b0, 8'h00, 4'b0000, 1'b0);
        vt[4]  = mk(4'b1000, 4'b1000, DA,  1'b1, 4'b0000, 1'b1, 8'hC2, 4'b0100, 1'b1);
        vt[5]  = mk(4'b1000, 4'b1000, DA,  1'b0, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b0);
        vt[6]  = mk(4'b0000, 4'b0000, DA,  1'b1, 4'b0000, 1'b1, 8'hD3, 4'b1000, 1'b1);
        vt[7]  = mk(4'b0000, 4'b0000, DA,  1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        vt[8]  = mk(4'b0000, 4'b0000, DA,  1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        vt[9]  = mk(4'b1010, 4'b1000, DA,  1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0);
        vt[10] = mk(4'b1010, 4'b1000, D42, 1'b0, 4'b0000, 1'b1, 8'h41, 4'b0010, 1'b1);
        vt[11] = mk(4'b1010, 4'b1000, D42, 1'b1, 4'b0000, 1'b1, 8'h41, 4'b0010, 1'b1);
        vt[12] = mk(4'b1010, 4'b1000, D42, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1);
        vt[13] = mk(4'b1010, 4'b1010, D43, 1'b1, 4'b0000, 1'b1, 8'h42, 4'b0010, 1'b1);
        vt[14] = mk(4'b1010, 4'b1010, D43, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1);
        vt[15] = mk(4'b1000, 4'b1000, D43, 1'b0, 4'b0000, 1'b1, 8'h43, 4'b0010, 1'b1);
        vt[16] = mk(4'b1000, 4'b1000, D43, 1'b1, 4'b0000, 1'b1, 8'h43, 4'b0010, 1'b1);
        vt[17] = mk(4'b1000, 4'b1000, D43, 1'b0, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b0);
        vt[18] = mk(4'b0000, 4'b0000, D43, 1'b1, 4'b0000, 1'b1, 8'hD3, 4'b1000, 1'b1);
        vt[19] = mk(4'b0000, 4'b0000, D43, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

        // outputs stay quiet under reset even with every requester valid
        drive4(4'b1111, 4'b1111, DA, 1'b1);
        #3;
        check4("reset", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        drive4(4'b0000, 4'b0000, DA, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            drive4(vt[i].v, vt[i].l, vt[i].d, vt[i].ack);
            #1;
            check4($sformatf("vec%0d", i), vt[i].rdy, vt[i].cyc, vt[i].dat, vt[i].g, vt[i].b);
            tick();
        end

        // lock timeout: req 1 opens a packet and stalls, req 0 waits
        drive4(4'b0010, 4'b0000, D55, 1'b0); #1;
        check4("lock.acc", 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0); tick();
        drive4(4'b0001, 4'b0000, D55, 1'b1); #1;
        check4("lock.xfer", 4'b0000, 1'b1, 8'h55, 4'b0010, 1'b1); tick();
        for (int i = 0; i < 8; i++) begin
            drive4(4'b0001, 4'b0000, D55, 1'b0); #1;
            check4($sformatf("lock.hold%0d", i), 4'b0000, 1'b0, 8'h00, 4'b0010, 1'b1);
            tick();
        end
        drive4(4'b0001, 4'b0000, D66, 1'b0); #1;
        check4("lock.rel", 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0); tick();

        // owner valid in the expiry cycle keeps the lock
        drive4(4'b0100, 4'b0000, D66, 1'b1); #1;
        check4("own.xfer", 4'b0000, 1'b1, 8'h66, 4'b0001, 1'b1); tick();
        for (int i = 0; i < 7; i++) begin
            drive4(4'b0100, 4'b0000, D66, 1'b0); #1;
            check4($sformatf("own.hold%0d", i), 4'b0000, 1'b0, 8'h00, 4'b0001, 1'b1);
            tick();
        end
        drive4(4'b0101, 4'b0001, D77, 1'b0); #1;
        check4("own.win", 4'b0001, 1'b0, 8'h00, 4'b0001, 1'b1); tick();
        drive4(4'b0100, 4'b0001, D77, 1'b1); #1;
        check4("own.xfer2", 4'b0000, 1'b1, 8'h77, 4'b0001, 1'b1); tick();

        // reset mid-transfer with ack withheld
        drive4(4'b0100, 4'b0100, D77, 1'b0); #1;
        check4("rst.acc", 4'b0100, 1'b0, 8'h00, 4'b0000, 1'b0); tick();
        drive4(4'b0000, 4'b0000, D77, 1'b0); #1;
        check4("rst.xfer", 4'b0000, 1'b1, 8'hC2, 4'b0100, 1'b1);
        rst_n = 1'b0;
        #1;
        check4("rst.now", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check4($sformatf("rst.noretry%0d", i), 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
            tick();
        end
        drive4(4'b1001, 4'b1001, DA, 1'b0); #1;
        check4("rst.ptr0", 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0); tick();
        drive4(4'b0000, 4'b0000, DA, 1'b1); #1;
        check4("rst.xfer0", 4'b0000, 1'b1, 8'hA0, 4'b0001, 1'b1); tick();
        drive4(4'b0000, 4'b0000, DA, 1'b0); #1;
        check4("rst.idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0); tick();

        // three requesters saturating the link
        v3 = 3'b111; l3 = 3'b111; ack3 = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("rr3.onehot%0d", c), 32'($countones(rdy3) <= 1), 32'd1);
            if (rdy3 != 3'b000) begin
                e3 = 3'(1 << (k % 3));
                chk($sformatf("rr3.grant%0d", k), 32'(rdy3), 32'(e3));
                k++;
            end
            tick();
        end
        chk("rr3.count", 32'(k), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
